// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: once the CPU halts, or when a start request arrives, this
// block takes over the memory testbench port. It reads every word from
// START_ADDR to END_ADDR inclusive and streams each (address, data) pair on a
// one-deep valid/ready interface.
// Optional build macro MEM_DUMP_SKIP_ZERO_EN: words that read back as zero are
// not emitted. They are counted on skipped_cnt instead.
module mem_dump_ctrl #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 16'h3FFC,
  parameter int                STRIDE     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              halt,
  input  logic              start,
  input  logic              mem_wait,
  input  logic [31:0]       load,
  output logic              tbCTRL,
  output logic              REN,
  output logic [31:0]       addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done
`ifdef MEM_DUMP_SKIP_ZERO_EN
  ,
  output logic [ADDR_W-1:0] skipped_cnt
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READ,
    HOLD,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic              halt_q;
  logic              trigger;
  logic              last_word;
  logic              skip_word;
  logic              do_arm;
  logic              do_capture;
  logic              do_accept;
  logic              do_advance;

  // A rising halt and a start pulse in the same cycle still make one trigger.
  assign trigger   = (halt & ~halt_q) | start;
  // The end-of-range check is made before the increment.
  // So a range ending at the top of the address space never wraps.
  assign last_word = (cur_addr == END_ADDR);
  assign addr      = {{(32-ADDR_W){1'b0}}, cur_addr};

`ifdef MEM_DUMP_SKIP_ZERO_EN
  assign skip_word = (load == 32'd0);
`else
  assign skip_word = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and memory-port / status outputs for each state.
  always_comb begin
    state_nxt  = state;
    do_arm     = 1'b0;
    do_capture = 1'b0;
    do_accept  = 1'b0;
    do_advance = 1'b0;
    tbCTRL     = 1'b0;
    REN        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          do_arm    = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        tbCTRL    = 1'b1;
        busy      = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        tbCTRL = 1'b1;
        REN    = 1'b1;
        busy   = 1'b1;
        if (!mem_wait) begin
          if (skip_word) begin
            if (last_word) state_nxt  = DONE;
            else           do_advance = 1'b1;
          end else begin
            do_capture = 1'b1;
            state_nxt  = HOLD;
          end
        end
      end
      HOLD: begin
        tbCTRL = 1'b1;
        busy   = 1'b1;
        if (out_valid && out_ready) begin
          do_accept = 1'b1;
          if (last_word) begin
            state_nxt = DONE;
          end else begin
            do_advance = 1'b1;
            state_nxt  = READ;
          end
        end
      end
      DONE: begin
        tbCTRL = 1'b1;
        done   = 1'b1;
        if (trigger) begin
          do_arm    = 1'b1;
          state_nxt = ARM;
        end else if (!halt) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Halt edge history, the address walk, and the one-deep output word buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_q    <= 1'b0;
      cur_addr  <= START_ADDR;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= 32'd0;
    end else begin
      halt_q <= halt;
      if (do_arm)          cur_addr <= START_ADDR;
      else if (do_advance) cur_addr <= cur_addr + STEP;
      if (do_capture) begin
        out_valid <= 1'b1;
        out_addr  <= cur_addr;
        out_data  <= load;
      end else if (do_accept) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MEM_DUMP_SKIP_ZERO_EN
  // Count zero words that were dropped. The count restarts with every dump.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                          skipped_cnt <= '0;
    else if (do_arm)                                  skipped_cnt <= '0;
    else if (state == READ && !mem_wait && skip_word) skipped_cnt <= skipped_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb_mem_dump_ctrl: directed bench for mem_dump_ctrl.
// dut covers bytes 0x0..0xC, and dut1 covers the single word at 0x20.
// A word-list model predicts the emitted (address, data) sequence.
// With MEM_DUMP_SKIP_ZERO_EN defined, the zero-skip behaviour is also exercised.
`timescale 1ns/1ps
module tb_mem_dump_ctrl;

  localparam logic [15:0] S0 = 16'h0000;
  localparam logic [15:0] E0 = 16'h000C;
  localparam logic [15:0] S1 = 16'h0020;
`ifdef MEM_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } word_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        halt, start, mem_wait, out_ready;
  logic [31:0] load, addr, out_data;
  logic        tbCTRL, REN, out_valid, busy, done;
  logic [15:0] out_addr;

  logic        halt1, start1, mem_wait1, out_ready1;
  logic [31:0] load1, addr1, out_data1;
  logic        tbCTRL1, REN1, out_valid1, busy1, done1;
  logic [15:0] out_addr1;
`ifdef MEM_DUMP_SKIP_ZERO_EN
  logic [15:0] skipped_cnt, skipped_cnt1;
`endif

  logic [31:0] mem [0:15];
  word_t       expQ[$];
  int          nCompared   = 0;
  int          nMismatched = 0;
  int          wordsSeen   = 0;
  logic        held        = 1'b0;
  logic [15:0] prevA       = '0;
  logic [31:0] prevD       = '0;

  assign load  = mem[addr[5:2]];
  assign load1 = addr1 + 32'h100;

  mem_dump_ctrl #(.ADDR_W(16), .START_ADDR(S0), .END_ADDR(E0), .STRIDE(4)) dut (
    .CLK(CLK), .RST(RST), .halt(halt), .start(start), .mem_wait(mem_wait),
    .load(load), .tbCTRL(tbCTRL), .REN(REN), .addr(addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
`ifdef MEM_DUMP_SKIP_ZERO_EN
    , .skipped_cnt(skipped_cnt)
`endif
  );

  mem_dump_ctrl #(.ADDR_W(16), .START_ADDR(S1), .END_ADDR(S1), .STRIDE(4)) dut1 (
    .CLK(CLK), .RST(RST), .halt(halt1), .start(start1), .mem_wait(mem_wait1),
    .load(load1), .tbCTRL(tbCTRL1), .REN(REN1), .addr(addr1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_addr(out_addr1), .out_data(out_data1),
    .busy(busy1), .done(done1)
`ifdef MEM_DUMP_SKIP_ZERO_EN
    , .skipped_cnt(skipped_cnt1)
`endif
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nCompared++;
    if (actual !== required) begin
      nMismatched++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic h, input logic s, input logic mw, input logic rdy);
    halt      = h;
    start     = s;
    mem_wait  = mw;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // The dump is the word list START..END in stride order.
  // Zero words are dropped when skipping is built in.
  task automatic buildExpected();
    logic [31:0] d;
    expQ.delete();
    for (int a = int'(S0); a <= int'(E0); a += 4) begin
      d = mem[a / 4];
      if (!(SKIP && d == 32'd0)) expQ.push_back('{a[15:0], d});
    end
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    checkOutput("done_reached", 32'(done), 32'd1);
  endtask

  // Runs every cycle on the non-active edge.
  // It checks port protocol, word hold stability, and each accepted word
  // against the expected word list.
  always @(negedge CLK) begin
    word_t w;
    if (RST) begin
      held = 1'b0;
    end else begin
      if (REN) checkOutput("ren_needs_owner", 32'(tbCTRL), 32'd1);
      if (REN) checkOutput("read_in_range", 32'(addr <= 32'(E0) && addr[1:0] == 2'b00), 32'd1);
      if (out_valid) checkOutput("no_read_while_held", 32'(REN), 32'd0);
      if (done) checkOutput("done_not_busy", 32'(busy), 32'd0);
      if (held) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_addr", 32'(out_addr), 32'(prevA));
        checkOutput("hold_data", out_data, prevD);
      end
      if (out_valid && out_ready) begin
        wordsSeen++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", 32'(out_addr), 32'hFFFF_FFFF);
        end else begin
          w = expQ.pop_front();
          checkOutput("word_addr", 32'(out_addr), 32'(w.a));
          checkOutput("word_data", out_data, w.d);
        end
      end
      held  = out_valid && !out_ready;
      prevA = out_addr;
      prevD = out_data;
    end
  end

  // Directed sequence: reset, halt-triggered dump, stall and backpressure,
  // single-word range, mid-dump reset, and optionally zero skipping.
  initial begin
    int w0;
    int n;
    logic [15:0] a1;
    logic [31:0] d1;

    for (int i = 0; i < 16; i++) mem[i] = 32'(i * 4) + 32'h100;
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    halt1 = 1'b0; start1 = 1'b0; mem_wait1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) tick();
    checkOutput("rst_tbCTRL", 32'(tbCTRL), 32'd0);
    checkOutput("rst_REN", 32'(REN), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_out_addr", 32'(out_addr), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_addr", addr, 32'd0);
    RST = 1'b0;
    tick();

    // Halt edge: four words streamed with no backpressure.
    buildExpected();
    w0 = wordsSeen;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("arm_tbCTRL", 32'(tbCTRL), 32'd1);
    checkOutput("arm_REN", 32'(REN), 32'd0);
    checkOutput("arm_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("read_REN", 32'(REN), 32'd1);
    checkOutput("read_addr", addr, 32'd0);
    checkOutput("read_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    checkOutput("first_addr", 32'(out_addr), 32'd0);
    checkOutput("first_data", out_data, 32'h100);
    waitDone(40);
    checkOutput("dump1_words", 32'(wordsSeen - w0), 32'd4);
    checkOutput("dump1_queue", 32'(expQ.size()), 32'd0);
    repeat (3) tick();
    checkOutput("done_keeps_port", 32'(tbCTRL), 32'd1);
    checkOutput("done_held", 32'(done), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("release_tbCTRL", 32'(tbCTRL), 32'd0);
    checkOutput("release_done", 32'(done), 32'd0);

    // Memory stall on address 0x4, then three cycles of backpressure.
    tick();
    buildExpected();
    w0 = wordsSeen;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!(REN && addr == 32'h4) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("reach_read4", 32'(REN && addr == 32'h4), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_REN", 32'(REN), 32'd1);
      checkOutput("stall_addr", addr, 32'h4);
      checkOutput("stall_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("cap_valid", 32'(out_valid), 32'd1);
    checkOutput("cap_addr", 32'(out_addr), 32'h4);
    checkOutput("cap_data", out_data, 32'h104);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_REN", 32'(REN), 32'd0);
      checkOutput("bp_data", out_data, 32'h104);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("next_REN", 32'(REN), 32'd1);
    checkOutput("next_addr", addr, 32'h8);
    waitDone(40);
    checkOutput("dump2_words", 32'(wordsSeen - w0), 32'd4);
    checkOutput("dump2_queue", 32'(expQ.size()), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();

    // Single-word range on dut1.
    halt1 = 1'b1;
    n = 0;
    a1 = '0;
    d1 = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid1 && out_ready1) begin
        n++;
        a1 = out_addr1;
        d1 = out_data1;
      end
    end
    checkOutput("single_count", 32'(n), 32'd1);
    checkOutput("single_addr", 32'(a1), 32'h20);
    checkOutput("single_data", d1, 32'h120);
    checkOutput("single_done", 32'(done1), 32'd1);
    checkOutput("single_busy", 32'(busy1), 32'd0);
    checkOutput("single_port", 32'(tbCTRL1 && !REN1), 32'd1);
    halt1 = 1'b0;

    // Start-triggered dump, reset while a word is held, then a halt restart.
    buildExpected();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("reach_hold", 32'(out_valid), 32'd1);
    #2 RST = 1'b1;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    checkOutput("async_tbCTRL", 32'(tbCTRL), 32'd0);
    checkOutput("async_REN", 32'(REN), 32'd0);
    expQ.delete();
    tick();
    RST = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    buildExpected();
    w0 = wordsSeen;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("restart_REN", 32'(REN), 32'd1);
    checkOutput("restart_addr", addr, 32'd0);
    waitDone(40);
    checkOutput("dump3_words", 32'(wordsSeen - w0), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();

`ifdef MEM_DUMP_SKIP_ZERO_EN
    // Zero words are dropped and counted.
    mem[0] = 32'd5; mem[1] = 32'd0; mem[2] = 32'd0; mem[3] = 32'd7;
    buildExpected();
    w0 = wordsSeen;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitDone(40);
    checkOutput("skip_words", 32'(wordsSeen - w0), 32'd2);
    checkOutput("skip_count", 32'(skipped_cnt), 32'd2);
    checkOutput("skip_queue", 32'(expQ.size()), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
